// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate-array self-test sequencer: FSM state codes,
// observation bit positions and the expected truth table.
package gate_bist_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Bit positions of each gate output inside obs
  localparam int unsigned AND_B  = 6;
  localparam int unsigned OR_B   = 5;
  localparam int unsigned NOR_B  = 4;
  localparam int unsigned NOT_B  = 3;
  localparam int unsigned NAND_B = 2;
  localparam int unsigned XOR_B  = 1;
  localparam int unsigned XNOR_B = 0;

  // Expected obs per vector index {a,b}; EXP[0] is the a=0,b=0 row
  localparam logic [3:0][6:0] EXP = {7'h61, 7'h26, 7'h2E, 7'h1D};

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus/result bundle between board control, the gate array and the
// self-test sequencer. The sequencer takes the slave view.
interface gate_bist_if #(
  parameter int unsigned ERRCNT_W = 8
);
  logic                start;
  logic [6:0]          obs;
  logic                drv_a;
  logic                drv_b;
  logic                busy;
  logic                done;
  logic                pass;
  logic [1:0]          fail_idx;
  logic [6:0]          err_mask;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output start, obs,
    input  drv_a, drv_b, busy, done, pass, fail_idx, err_mask, err_count
  );

  modport slave (
    input  start, obs,
    output drv_a, drv_b, busy, done, pass, fail_idx, err_mask, err_count
  );
endinterface

// File: rtl/gate_bist_cmp.sv
// Per-gate comparator: flags every obs bit that differs from the truth-table
// row selected by idx.
module gate_bist_cmp
  import gate_bist_pkg::*;
(
  input  logic [1:0] idx,
  input  logic [6:0] obs,
  output logic [6:0] mism
);

  logic [6:0] exp_v;

  assign exp_v = EXP[idx];

  assign mism[AND_B]  = obs[AND_B]  ^ exp_v[AND_B];
  assign mism[OR_B]   = obs[OR_B]   ^ exp_v[OR_B];
  assign mism[NOR_B]  = obs[NOR_B]  ^ exp_v[NOR_B];
  assign mism[NOT_B]  = obs[NOT_B]  ^ exp_v[NOT_B];
  assign mism[NAND_B] = obs[NAND_B] ^ exp_v[NAND_B];
  assign mism[XOR_B]  = obs[XOR_B]  ^ exp_v[XOR_B];
  assign mism[XNOR_B] = obs[XNOR_B] ^ exp_v[XNOR_B];

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for the two-input gate array. Steps a,b through all four
// vectors, holds each for SETTLE_CYCLES, then checks the seven gate outputs.
// Optional feature macro: GATE_BIST_ERRCNT_EN (cumulative saturating mismatch
// counter on err_count; tied to zero when undefined).
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0,
  parameter int unsigned ERRCNT_W      = 8
) (
  input logic        clk,
  input logic        rst,
  gate_bist_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]       state;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [CNT_W-1:0] settle;
  logic [6:0]       mism;
  logic [6:0]       mask_nxt;
  logic             last;

  gate_bist_cmp u_cmp (
    .idx  (idx),
    .obs  (bus.obs),
    .mism (mism)
  );

  assign idx_nxt  = idx + 2'd1;
  assign mask_nxt = bus.err_mask | mism;
  assign last     = (idx == 2'd3) || (STOP_ON_FAIL && (mism != '0));

  // Sequencer FSM and all registered outputs; busy/done/pass/drv are set on
  // the transition edge so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      settle       <= '0;
      bus.drv_a    <= 1'b0;
      bus.drv_b    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
      bus.fail_idx <= '0;
      bus.err_mask <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= APPLY;
            idx          <= '0;
            settle       <= CNT_W'(SETTLE_CYCLES);
            bus.drv_a    <= 1'b0;
            bus.drv_b    <= 1'b0;
            bus.busy     <= 1'b1;
            bus.pass     <= 1'b0;
            bus.fail_idx <= '0;
            bus.err_mask <= '0;
          end
        end
        APPLY: begin
          if (settle == CNT_W'(1)) begin
            state <= CHECK;
          end else begin
            settle <= settle - 1'b1;
          end
        end
        CHECK: begin
          bus.err_mask <= mask_nxt;
          // An all-zero mask before this update means no earlier vector failed
          if ((mism != '0) && (bus.err_mask == '0)) begin
            bus.fail_idx <= idx;
          end
          if (last) begin
            state     <= DONE;
            bus.done  <= 1'b1;
            bus.pass  <= (mask_nxt == '0);
            bus.drv_a <= 1'b0;
            bus.drv_b <= 1'b0;
          end else begin
            state     <= APPLY;
            idx       <= idx_nxt;
            settle    <= CNT_W'(SETTLE_CYCLES);
            bus.drv_a <= idx_nxt[1];
            bus.drv_b <= idx_nxt[0];
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GATE_BIST_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q;

  // Cumulative mismatching-vector counter; survives start, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if ((state == CHECK) && (mism != '0) && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = ERRCNT_W'(0);
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: three sequencer instances (default,
// abort-on-fail, one-cycle settle) each driven by a behavioural gate array
// that can be switched between healthy, faulty and delayed behaviour.
module tb_gate_bist_ctrl;

`ifdef GATE_BIST_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  // Gate-array behaviour: 0 healthy, 1 xor stuck-at-0, 2 and inverted, 3 two-cycle delay
  logic [1:0] mode0 = 2'd0;
  logic [1:0] mode1 = 2'd0;
  logic [1:0] mode2 = 2'd0;
  logic [6:0] p0a, p0b, p1a, p1b, p2a, p2b;

  gate_bist_if #(.ERRCNT_W(8)) bus0 ();
  gate_bist_if #(.ERRCNT_W(8)) bus1 ();
  gate_bist_if #(.ERRCNT_W(8)) bus2 ();

  gate_bist_ctrl #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0), .ERRCNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0));
  gate_bist_ctrl #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1), .ERRCNT_W(8)) u_dut_stop (
    .clk(clk), .rst(rst), .bus(bus1));
  gate_bist_ctrl #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0), .ERRCNT_W(8)) u_dut_s1 (
    .clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // {and, or, nor, not a, nand, xor, xnor}
  function automatic logic [6:0] gates(input logic a, input logic b);
    return {a & b, a | b, ~(a | b), ~a, ~(a & b), a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [6:0] apply_mode(input logic [1:0] m, input logic [6:0] g,
                                            input logic [6:0] dly);
    case (m)
      2'd1:    return g & 7'h7D;
      2'd2:    return g ^ 7'h40;
      2'd3:    return dly;
      default: return g;
    endcase
  endfunction

  // Two-register delay line per gate array
  always @(posedge clk) begin
    p0a <= gates(bus0.drv_a, bus0.drv_b); p0b <= p0a;
    p1a <= gates(bus1.drv_a, bus1.drv_b); p1b <= p1a;
    p2a <= gates(bus2.drv_a, bus2.drv_b); p2b <= p2a;
  end

  assign bus0.obs = apply_mode(mode0, gates(bus0.drv_a, bus0.drv_b), p0b);
  assign bus1.obs = apply_mode(mode1, gates(bus1.drv_a, bus1.drv_b), p1b);
  assign bus2.obs = apply_mode(mode2, gates(bus2.drv_a, bus2.drv_b), p2b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_start(input int unsigned sel, input logic v);
    case (sel)
      0:       bus0.start = v;
      1:       bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  function automatic logic done_of(input int unsigned sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  // Pulse start and count cycles until done; the accept cycle is cycle 1
  task automatic run(input int unsigned sel, output int unsigned lat);
    set_start(sel, 1'b1);
    step();
    set_start(sel, 1'b0);
    lat = 1;
    while (!done_of(sel) && (lat < 200)) begin
      step();
      lat++;
    end
    if (!done_of(sel)) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned lat;
    int unsigned dones;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    do_reset();

    // Reset state
    check("rst_busy",  32'(bus0.busy), 32'd0);
    check("rst_done",  32'(bus0.done), 32'd0);
    check("rst_pass",  32'(bus0.pass), 32'd0);
    check("rst_drv",   32'({bus0.drv_a, bus0.drv_b}), 32'd0);
    check("rst_fidx",  32'(bus0.fail_idx), 32'd0);
    check("rst_mask",  32'(bus0.err_mask), 32'd0);
    check("rst_cnt",   32'(bus0.err_count), 32'd0);

    // Healthy array, single run
    run(0, lat);
    check("t1_lat",   lat, 32'd13);
    check("t1_pass",  32'(bus0.pass), 32'd1);
    check("t1_mask",  32'(bus0.err_mask), 32'h00);
    check("t1_fidx",  32'(bus0.fail_idx), 32'd0);
    check("t1_busy",  32'(bus0.busy), 32'd1);
    check("t1_drv",   32'({bus0.drv_a, bus0.drv_b}), 32'd0);
    step();
    check("t1_done_pulse", 32'(bus0.done), 32'd0);
    check("t1_busy_off",   32'(bus0.busy), 32'd0);
    check("t1_pass_hold",  32'(bus0.pass), 32'd1);

    // Reset during APPLY of vector 2
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int i = 2; i <= 8; i++) step();
    check("t4_drv_idx2", 32'({bus0.drv_a, bus0.drv_b}), 32'd2);
    rst = 1'b1;
    step();
    check("t4_busy", 32'(bus0.busy), 32'd0);
    check("t4_drv",  32'({bus0.drv_a, bus0.drv_b}), 32'd0);
    check("t4_pass", 32'(bus0.pass), 32'd0);
    check("t4_done", 32'(bus0.done), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus0.done) dones++;
    end
    check("t4_no_done", dones, 32'd0);
    run(0, lat);
    check("t4_rerun_lat",  lat, 32'd13);
    check("t4_rerun_pass", 32'(bus0.pass), 32'd1);

    // xor output stuck-at-0
    do_reset();
    mode0 = 2'd1;
    run(0, lat);
    check("t2_lat",  lat, 32'd13);
    check("t2_pass", 32'(bus0.pass), 32'd0);
    check("t2_fidx", 32'(bus0.fail_idx), 32'd1);
    check("t2_mask", 32'(bus0.err_mask), 32'h02);
    check("t2_cnt",  32'(bus0.err_count), CNT_EN ? 32'd2 : 32'd0);
    step();
    run(0, lat);
    check("t2_cnt_cum", 32'(bus0.err_count), CNT_EN ? 32'd4 : 32'd0);
    for (int r = 0; r < 126; r++) begin
      step();
      run(0, lat);
    end
    check("t2_cnt_sat", 32'(bus0.err_count), CNT_EN ? 32'd255 : 32'd0);
    mode0 = 2'd0;

    // Abort on first failing vector
    do_reset();
    mode1 = 2'd2;
    run(1, lat);
    check("t3_lat",  lat, 32'd4);
    check("t3_pass", 32'(bus1.pass), 32'd0);
    check("t3_fidx", 32'(bus1.fail_idx), 32'd0);
    check("t3_mask", 32'(bus1.err_mask), 32'h40);
    mode1 = 2'd0;

    // start held high: back-to-back runs
    do_reset();
    bus0.start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (bus0.done && (n <= 28)) dones++;
      if (n == 13 || n == 27) check("t5_done_at", 32'(bus0.done), 32'd1);
      if (n == 2 || n == 5 || n == 8 || n == 11)
        check("t5_drv_run1", 32'({bus0.drv_a, bus0.drv_b}), 32'((n - 2) / 3));
      if (n == 16 || n == 19 || n == 22 || n == 25)
        check("t5_drv_run2", 32'({bus0.drv_a, bus0.drv_b}), 32'((n - 16) / 3));
    end
    check("t5_done_count", dones, 32'd2);
    bus0.start = 1'b0;

    // Two-cycle obs delay against short and default settle
    do_reset();
    mode2 = 2'd3;
    run(2, lat);
    check("t6_s1_lat",  lat, 32'd9);
    check("t6_s1_pass", 32'(bus2.pass), 32'd0);
    check("t6_s1_fidx", 32'(bus2.fail_idx), 32'd1);
    check("t6_s1_mask", 32'(bus2.err_mask), 32'h7F);
    mode0 = 2'd3;
    run(0, lat);
    check("t6_s2_lat",  lat, 32'd13);
    check("t6_s2_pass", 32'(bus0.pass), 32'd1);
    check("t6_s2_mask", 32'(bus0.err_mask), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
